// File: rtl/mem_access_stage.sv
// mem_access_stage: registers execute results, runs req/ack data-memory accesses with a
// bounded wait, resolves branches and presents write-back data; stalls upstream while waiting.
module mem_access_stage #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_n,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [15:0]       ex_alu_result,
    input  logic [15:0]       ex_register2_data,
    input  logic [2:0]        ex_reg_waddr,
    input  logic              ex_alu_z,
    input  logic [6:0]        ex_sign_ext_next_addr,
    input  logic              cu_mem_read,
    input  logic              cu_mem_write,
    input  logic              cu_reg_write,
    input  logic              cu_branch,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [15:0]       dm_wdata,
    input  logic [15:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              mem_stall,
    output logic              mem_wb_valid,
    output logic              mem_reg_we,
    output logic [2:0]        mem_reg_waddr,
    output logic [15:0]       mem_reg_wdata,
    output logic              mem_branch_taken,
    output logic [6:0]        mem_branch_addr,
    output logic              mem_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic [2:0] hold_waddr;
    logic       mem_op;
    logic       done;
    assign mem_op    = cu_mem_read | cu_mem_write;
    assign mem_stall = (state == WAIT);
    // an ack on the last permitted wait cycle wins over the abort
    assign done      = dm_ack | (cnt == 8'(TIMEOUT - 1));
    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            hold_waddr       <= '0;
            dm_req           <= 1'b0;
            dm_we            <= 1'b0;
            dm_addr          <= '0;
            dm_wdata         <= '0;
            mem_wb_valid     <= 1'b0;
            mem_reg_we       <= 1'b0;
            mem_reg_waddr    <= '0;
            mem_reg_wdata    <= '0;
            mem_branch_taken <= 1'b0;
            mem_branch_addr  <= '0;
            mem_err          <= 1'b0;
        end else begin
            mem_wb_valid     <= 1'b0;
            mem_reg_we       <= 1'b0;
            mem_branch_taken <= 1'b0;
            if (state == IDLE) begin
                if (ex_valid) begin
                    mem_branch_taken <= cu_branch & ex_alu_z;
                    mem_branch_addr  <= ex_sign_ext_next_addr;
                    if (mem_op) begin
                        state      <= WAIT;
                        cnt        <= '0;
                        dm_req     <= 1'b1;
                        dm_we      <= cu_mem_write;
                        dm_addr    <= ex_alu_result[ADDR_W-1:0];
                        dm_wdata   <= ex_register2_data;
                        hold_waddr <= ex_reg_waddr;
                    end else begin
                        mem_wb_valid  <= 1'b1;
                        mem_reg_we    <= cu_reg_write;
                        mem_reg_waddr <= ex_reg_waddr;
                        mem_reg_wdata <= ex_alu_result;
                    end
                end
            end else if (done) begin
                state         <= IDLE;
                dm_req        <= 1'b0;
                mem_wb_valid  <= 1'b1;
                mem_reg_we    <= dm_ack & ~dm_we;
                mem_reg_waddr <= hold_waddr;
                mem_reg_wdata <= (dm_ack & ~dm_we) ? dm_rdata : mem_reg_wdata;
                mem_err       <= mem_err | ~dm_ack;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven directed vectors, hand sequences for reset/idle-ack,
// and randomized instructions checked against a transaction-level model.
module tb_mem_access_stage;
    localparam int TO = 15;
    logic        clk_n = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 0, ex_alu_z = 0;
    logic [15:0] ex_alu_result = 0, ex_register2_data = 0, dm_rdata = 0;
    logic [2:0]  ex_reg_waddr = 0;
    logic [6:0]  ex_sign_ext_next_addr = 0;
    logic        cu_mem_read = 0, cu_mem_write = 0, cu_reg_write = 0, cu_branch = 0, dm_ack = 0;
    logic        dm_req, dm_we, mem_stall, mem_wb_valid, mem_reg_we, mem_branch_taken, mem_err;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata, mem_reg_wdata;
    logic [2:0]  mem_reg_waddr;
    logic [6:0]  mem_branch_addr;
    int n_cmp = 0, n_bad = 0;
    logic err_m = 0;

    mem_access_stage #(.ADDR_W(8), .TIMEOUT(TO)) dut (
        .clk_n(clk_n), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_register2_data(ex_register2_data), .ex_reg_waddr(ex_reg_waddr), .ex_alu_z(ex_alu_z),
        .ex_sign_ext_next_addr(ex_sign_ext_next_addr), .cu_mem_read(cu_mem_read),
        .cu_mem_write(cu_mem_write), .cu_reg_write(cu_reg_write), .cu_branch(cu_branch),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid),
        .mem_reg_we(mem_reg_we), .mem_reg_waddr(mem_reg_waddr), .mem_reg_wdata(mem_reg_wdata),
        .mem_branch_taken(mem_branch_taken), .mem_branch_addr(mem_branch_addr), .mem_err(mem_err));

    always #5 clk_n = ~clk_n;

    typedef struct {
        logic rd, wr, rw, br, z;
        logic [15:0] res, d2, rdata;
        logic [2:0]  wa;
        logic [6:0]  tgt;
        int          k;
        logic        exp_we, exp_bt, exp_err;
        logic [15:0] exp_wdata;
        int          exp_reqs;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_n);
        #1;
    endtask

    // drive one instruction and follow it through to write-back
    task automatic run_vec(input vec_t v);
        ex_valid = 1; cu_mem_read = v.rd; cu_mem_write = v.wr; cu_reg_write = v.rw;
        cu_branch = v.br; ex_alu_z = v.z; ex_alu_result = v.res; ex_register2_data = v.d2;
        ex_reg_waddr = v.wa; ex_sign_ext_next_addr = v.tgt;
        tick();
        ex_valid = 0;
        chk("branch_taken", mem_branch_taken, v.exp_bt);
        if (v.exp_bt) chk("branch_addr", mem_branch_addr, v.tgt);
        chk("stall_after_accept", mem_stall, v.exp_reqs != 0);
        for (int c = 0; c < v.exp_reqs; c++) begin
            chk("req_held", dm_req, 1);
            chk("stall_wait", mem_stall, 1);
            chk("no_early_wb", mem_wb_valid, 0);
            chk("dm_we", dm_we, v.wr);
            chk("dm_addr", dm_addr, v.res[7:0]);
            if (v.wr) chk("dm_wdata", dm_wdata, v.d2);
            ex_valid = 1'($urandom); ex_alu_result = 16'($urandom); cu_mem_read = 1'($urandom);
            dm_ack = (c == v.k); dm_rdata = (c == v.k) ? v.rdata : 16'($urandom);
            tick();
            dm_ack = 0; ex_valid = 0;
        end
        chk("wb_valid", mem_wb_valid, 1);
        chk("reg_we", mem_reg_we, v.exp_we);
        chk("reg_waddr", mem_reg_waddr, v.wa);
        if (v.exp_we || !(v.rd | v.wr)) chk("reg_wdata", mem_reg_wdata, v.exp_wdata);
        chk("req_dropped", dm_req, 0);
        chk("stall_end", mem_stall, 0);
        chk("mem_err", mem_err, v.exp_err);
        tick();
        chk("wb_single", mem_wb_valid, 0);
        chk("bt_single", mem_branch_taken, 0);
    endtask

    // reference: transaction outcome from the access rules, with sticky error tracking
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic mop = v.rd | v.wr;
        logic tmo = mop && v.k >= TO;
        r.exp_bt    = v.br & v.z;
        r.exp_reqs  = mop ? ((v.k + 1 < TO) ? v.k + 1 : TO) : 0;
        r.exp_we    = mop ? (!v.wr && !tmo) : v.rw;
        r.exp_wdata = mop ? v.rdata : v.res;
        err_m       = err_m | tmo;
        r.exp_err   = err_m;
        return r;
    endfunction

    function automatic vec_t mk(input logic rd, wr, rw, br, z, input logic [15:0] res, d2,
                                input logic [2:0] wa, input logic [6:0] tgt, input int k,
                                input logic [15:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.br = br; v.z = z; v.res = res; v.d2 = d2;
        v.wa = wa; v.tgt = tgt; v.k = k; v.rdata = rdata;
        v.exp_we = 0; v.exp_bt = 0; v.exp_err = 0; v.exp_wdata = 0; v.exp_reqs = 0;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t v;
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        tick(); tick();
        chk("reset_outputs", {dm_req, dm_we, dm_addr, dm_wdata, mem_wb_valid, mem_reg_we,
            mem_reg_waddr, mem_reg_wdata, mem_branch_taken, mem_branch_addr, mem_err, mem_stall}, 0);
        rst_n = 1;
        tick();
        //          rd wr rw br z  res       d2        wa tgt     k   rdata    we bt err wdata    reqs
        v = mk(0,0,1,0,0, 16'h1234, 16'h0,    3, 7'h00, 0,  16'h0);    v.exp_we=1; v.exp_wdata=16'h1234; tbl.push_back(v);
        v = mk(0,0,0,1,1, 16'h0000, 16'h0,    1, 7'h15, 0,  16'h0);    v.exp_bt=1; tbl.push_back(v);
        v = mk(0,0,1,1,0, 16'h0001, 16'h0,    2, 7'h15, 0,  16'h0);    v.exp_we=1; v.exp_wdata=16'h0001; tbl.push_back(v);
        v = mk(1,0,1,0,0, 16'h0042, 16'h0,    5, 7'h00, 2,  16'hBEEF); v.exp_we=1; v.exp_wdata=16'hBEEF; v.exp_reqs=3; tbl.push_back(v);
        v = mk(0,1,0,0,0, 16'h0010, 16'hA5A5, 6, 7'h00, 0,  16'h0);    v.exp_reqs=1; tbl.push_back(v);
        v = mk(1,1,1,1,1, 16'h0077, 16'h5A5A, 7, 7'h2A, 1,  16'h1111); v.exp_bt=1; v.exp_reqs=2; tbl.push_back(v);
        v = mk(1,0,1,0,0, 16'h00FF, 16'h0,    4, 7'h00, 14, 16'hC0DE); v.exp_we=1; v.exp_wdata=16'hC0DE; v.exp_reqs=15; tbl.push_back(v);
        v = mk(1,0,1,0,0, 16'h0033, 16'h0,    1, 7'h00, 99, 16'h0);    v.exp_reqs=15; v.exp_err=1; tbl.push_back(v);
        v = mk(0,0,1,0,0, 16'h4321, 16'h0,    2, 7'h00, 0,  16'h0);    v.exp_we=1; v.exp_wdata=16'h4321; v.exp_err=1; tbl.push_back(v);
        foreach (tbl[i]) run_vec(tbl[i]);
        // stray ack and idle cycles produce nothing
        dm_ack = 1; tick(); dm_ack = 0; tick();
        chk("idle_ack_wb", mem_wb_valid, 0);
        chk("idle_ack_stall", mem_stall, 0);
        chk("idle_err_sticky", mem_err, 1);
        // reset in the middle of a wait
        ex_valid = 1; cu_mem_read = 1; cu_mem_write = 0; ex_alu_result = 16'h0099;
        tick();
        ex_valid = 0;
        tick(); tick(); tick();
        chk("pre_reset_req", dm_req, 1);
        rst_n = 0;
        #1;
        chk("async_reset_outputs", {dm_req, dm_we, dm_addr, dm_wdata, mem_wb_valid, mem_reg_we,
            mem_reg_waddr, mem_reg_wdata, mem_branch_taken, mem_branch_addr, mem_err, mem_stall}, 0);
        tick();
        rst_n = 1;
        tick();
        err_m = 0;
        run_vec(model(mk(1,0,0,0,0, 16'h0055, 16'h0, 3, 7'h00, 1, 16'h7E57)));
        for (int i = 0; i < 150; i++) begin
            logic [1:0] op = 2'($urandom);
            int k = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
            run_vec(model(mk(op[0], op[1], 1'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom), 16'($urandom), 3'($urandom), 7'($urandom), k, 16'($urandom))));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the omicron pipeline, directly downstream of the execute stage. Registers execute results, performs load/store transactions on a req/ack data-memory port with a bounded wait, resolves branches, and presents write-back data to the register file. While a memory transaction is outstanding it stalls the upstream stages.

## Interface
Parameters:
- ADDR_W, 8, data-memory address width; the address is taken from ex_alu_result[ADDR_W-1:0]
- TIMEOUT, 15, maximum number of WAIT cycles without dm_ack before the access is aborted (valid range 1..255)

Ports:
- clk_n  in  1  single clock; all state updates on posedge clk_n
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute outputs carry a live instruction
- ex_alu_result  in  16  ALU result; the memory address for load/store
- ex_register2_data  in  16  store data
- ex_reg_waddr  in  3  destination register
- ex_alu_z  in  1  ALU zero flag
- ex_sign_ext_next_addr  in  7  branch target
- cu_mem_read, cu_mem_write, cu_reg_write, cu_branch  in  1 each  control bits for the instruction
- dm_req  out  1  memory request, held until ack or abort
- dm_we  out  1  1 = write
- dm_addr  out  ADDR_W  access address
- dm_wdata  out  16  store data
- dm_rdata  in  16  load data, valid when dm_ack=1
- dm_ack  in  1  one-cycle completion strobe
- mem_stall  out  1  upstream must hold its outputs
- mem_wb_valid  out  1  one-cycle strobe: write-back fields valid
- mem_reg_we  out  1  register-file write enable (qualified by mem_wb_valid)
- mem_reg_waddr  out  3  write-back register
- mem_reg_wdata  out  16  write-back data
- mem_branch_taken  out  1  one-cycle strobe
- mem_branch_addr  out  7  branch target
- mem_err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE and WAIT. mem_stall = (state == WAIT), combinational.
- IDLE with ex_valid=1 accepts the instruction:
  - Branch: mem_branch_taken <= cu_branch & ex_alu_z; mem_branch_addr <= ex_sign_ext_next_addr. Branch resolution is independent of memory control bits.
  - No memory op: next cycle mem_wb_valid=1, mem_reg_we=cu_reg_write, mem_reg_waddr=ex_reg_waddr, mem_reg_wdata=ex_alu_result.
  - Memory op (cu_mem_read | cu_mem_write): latch address, store data, dest and op into holding registers; go to WAIT. dm_req=1 and dm_we=cu_mem_write from the next cycle. If both read and write are set, the access is a write.
- WAIT: dm_req, dm_we, dm_addr and dm_wdata are held stable; wait counter increments each cycle; ex_* inputs are ignored.
  - dm_ack=1: dm_req drops the next cycle; return to IDLE; one-cycle mem_wb_valid. A load produces mem_reg_we=1 with mem_reg_wdata=dm_rdata (sampled on the ack cycle). A store produces mem_reg_we=0.
  - Counter reaches TIMEOUT with no ack: abort; dm_req drops; mem_err <= 1; mem_wb_valid pulses with mem_reg_we=0; return to IDLE.
- dm_ack received in IDLE is ignored.
- mem_err is cleared only by reset.
- ex_valid=0 in IDLE: no strobes are produced.

## Timing
- Reset (async): state IDLE, counter 0. All outputs are 0: dm_req, dm_we, dm_addr, dm_wdata, mem_wb_valid, mem_reg_we, mem_reg_waddr, mem_reg_wdata, mem_branch_taken, mem_branch_addr, mem_err. mem_stall is 0.
- Reset asserted during WAIT drops dm_req immediately, with no write-back.
- Latency:
  - Non-memory instruction: write-back 1 cycle after acceptance.
  - Branch strobe: 1 cycle after acceptance.
  - Memory op: dm_req rises 1 cycle after acceptance. With ack k cycles after req rises (k≥0, ack allowed on the first req cycle), mem_wb_valid is asserted the cycle after ack.
- Timeout: abort occurs at the edge ending the TIMEOUT-th WAIT cycle without ack. dm_req has been high for exactly TIMEOUT cycles.
- mem_stall is high for every WAIT cycle, including the ack cycle. Consequently at most one memory op is in flight, and there is a 1-cycle bubble after each access.
- Strobes (mem_wb_valid, mem_branch_taken) are single-cycle and registered.

## Test plan
- ALU op: ex_valid=1, cu_reg_write=1, result 16'h1234, waddr 3 -> next cycle wb_valid=1, we=1, waddr=3, wdata=16'h1234; stall never high.
- Load: addr 16'h0042, ack 2 cycles after req with rdata 16'hBEEF -> dm_addr=8'h42, dm_we=0, stall high 3 cycles, wdata=16'hBEEF with we=1 the cycle after ack.
- Store: addr 16'h0010, data 16'hA5A5, ack on first req cycle -> dm_we=1, dm_wdata=16'hA5A5, wb_valid with we=0, exactly one stall cycle.
- Branch: cu_branch=1, z=1, target 7'h15 -> branch_taken pulse with addr 7'h15; z=0 -> no pulse.
- Timeout: load with ack never asserted, TIMEOUT=15 -> req high 15 cycles then low, mem_err=1 stays set, wb_valid with we=0; a later ALU op completes normally.
- Reset mid-WAIT: rst_n low during WAIT -> dm_req=0 at once, all outputs 0; after release, a new load completes normally.
